// File: rtl/pipe_skid_stage_pkg.sv
// IF->ID payload layout shared by the fetch stage, the boundary buffer and decode.
// Field offsets are the single source of truth; pack/unpack keep callers off raw bit slices.
package pipe_pkg;

  localparam int PC_WIDTH        = 32;
  localparam int INSTR_WIDTH     = 32;
  localparam int SPARE_WIDTH     = 31;

  localparam int PC_LSB          = 0;
  localparam int INSTR_LSB       = PC_LSB + PC_WIDTH;
  localparam int PRDT_TAKEN_BIT  = INSTR_LSB + INSTR_WIDTH;
  localparam int PC_MISALIGN_BIT = PRDT_TAKEN_BIT + 1;
  localparam int BUS_ERR_BIT     = PC_MISALIGN_BIT + 1;
  localparam int IFID_DATA_W     = BUS_ERR_BIT + 1 + SPARE_WIDTH;

  typedef struct packed {
    logic [SPARE_WIDTH-1:0] spare;
    logic                   bus_err;
    logic                   pc_misalign;
    logic                   prdt_taken;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } ifid_payload_t;

  function automatic logic [IFID_DATA_W-1:0] ifid_pack(
    input logic [PC_WIDTH-1:0]    pc,
    input logic [INSTR_WIDTH-1:0] instr,
    input logic                   prdt_taken,
    input logic                   pc_misalign,
    input logic                   bus_err
  );
    logic [IFID_DATA_W-1:0] d;
    d                             = '0;
    d[PC_LSB +: PC_WIDTH]         = pc;
    d[INSTR_LSB +: INSTR_WIDTH]   = instr;
    d[PRDT_TAKEN_BIT]             = prdt_taken;
    d[PC_MISALIGN_BIT]            = pc_misalign;
    d[BUS_ERR_BIT]                = bus_err;
    return d;
  endfunction

  function automatic ifid_payload_t ifid_unpack(input logic [IFID_DATA_W-1:0] d);
    return ifid_payload_t'(d);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// valid/ready/data handshake bundle; master drives valid+data, slave drives ready.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = IFID_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Deliberately unreset; the controller never presents an entry it has not written.
module pipe_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_skid_stage.sv
// IF->ID boundary buffer: DEPTH-entry circular queue with registered upstream ready,
// synchronous flush and a consumer-side hold. Control state is just pointers + count.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter  int DATA_W = IFID_DATA_W,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  pipe_skid_stage_if.slave  up,
  pipe_skid_stage_if.master dn,
  input  logic             flush,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  logic             rst_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // ready depends only on registered state (plus the reset input), never on dn.ready
  assign up.ready = ~rst & ~rst_q & (count != CNT_W'(DEPTH));
  assign dn.valid = (count != '0) & ~hold;

  assign push = up.valid & up.ready & ~flush;
  assign pop  = dn.valid & dn.ready & ~flush;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  pipe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (up.data),
    .raddr (rd_ptr),
    .rdata (dn.data)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench: a DEPTH=2 instance (reset/stream/full/flush/hold) and a DEPTH=4 instance (wrap).
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int DW_A = IFID_DATA_W;
  localparam int DW_B = 16;

  logic clk = 1'b0;
  logic rst;
  logic a_flush, a_hold, b_flush, b_hold;
  logic [1:0] a_count;
  logic [2:0] b_count;

  pipe_skid_stage_if #(.DATA_W(DW_A)) a_up ();
  pipe_skid_stage_if #(.DATA_W(DW_A)) a_dn ();
  pipe_skid_stage_if #(.DATA_W(DW_B)) b_up ();
  pipe_skid_stage_if #(.DATA_W(DW_B)) b_dn ();

  pipe_skid_stage #(.DATA_W(DW_A), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .up(a_up.slave), .dn(a_dn.master),
    .flush(a_flush), .hold(a_hold), .count(a_count)
  );

  pipe_skid_stage #(.DATA_W(DW_B), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .up(b_up.slave), .dn(b_dn.master),
    .flush(b_flush), .hold(b_hold), .count(b_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW_A-1:0] a_q[$];
  logic [DW_B-1:0] b_q[$];
  bit a_rst_q = 1'b1, b_rst_q = 1'b1;
  bit a_pop = 1'b0, b_pop = 1'b0;
  bit a_acc = 1'b0, b_acc = 1'b0;
  bit a_exp_valid, b_exp_valid;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue content is the expected buffer content, updated at each edge.
  always @(posedge clk) begin
    a_acc = a_up.valid && !rst && !a_rst_q && (a_q.size() != 2) && !a_flush;
    if (rst || a_flush) a_q.delete();
    else begin
      if (a_pop) void'(a_q.pop_front());
      if (a_acc) a_q.push_back(a_up.data);
    end
    a_rst_q = rst;
    a_pop   = 1'b0;

    b_acc = b_up.valid && !rst && !b_rst_q && (b_q.size() != 4) && !b_flush;
    if (rst || b_flush) b_q.delete();
    else begin
      if (b_pop) void'(b_q.pop_front());
      if (b_acc) b_q.push_back(b_up.data);
    end
    b_rst_q = rst;
    b_pop   = 1'b0;
  end

  // Monitor: compares DUT outputs mid-cycle and flags the pop the next edge will apply.
  always @(negedge clk) begin
    a_exp_valid = (a_q.size() != 0) && !a_hold;
    chk("a_in_ready",  a_up.ready, !rst && !a_rst_q && (a_q.size() != 2));
    chk("a_out_valid", a_dn.valid, a_exp_valid);
    chk("a_count",     a_count,    a_q.size());
    a_pop = a_exp_valid && a_dn.ready && !a_flush;
    if (a_pop) chk("a_out_data", a_dn.data, a_q[0]);

    b_exp_valid = (b_q.size() != 0) && !b_hold;
    chk("b_in_ready",  b_up.ready, !rst && !b_rst_q && (b_q.size() != 4));
    chk("b_out_valid", b_dn.valid, b_exp_valid);
    chk("b_count",     b_count,    b_q.size());
    b_pop = b_exp_valid && b_dn.ready && !b_flush;
    if (b_pop) chk("b_out_data", b_dn.data, b_q[0]);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_send(input logic [DW_A-1:0] d);
    int t = 0;
    a_up.valid = 1'b1;
    a_up.data  = d;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!a_acc && t < 50);
    chk("a_send_accept", a_acc, 1'b1);
    a_up.valid = 1'b0;
  endtask

  initial begin
    int unsigned seed;
    int t;
    rst = 1'b1;
    a_flush = 1'b0; a_hold = 1'b0; b_flush = 1'b0; b_hold = 1'b0;
    a_up.valid = 1'b1; a_up.data = DW_A'(8'h77); a_dn.ready = 1'b1;
    b_up.valid = 1'b1; b_up.data = DW_B'(8'h77); b_dn.ready = 1'b1;

    // reset with producers asserting valid
    idle(3);
    rst = 1'b0;
    a_up.valid = 1'b0;
    b_up.valid = 1'b0;
    idle(3);

    // streaming at full rate: each accept must take exactly one cycle
    for (int i = 1; i <= 16; i++) begin
      t = $time;
      a_send(DW_A'(i));
      chk("a_stream_rate", ($time - t) / 10, 1);
    end
    idle(3);

    // backpressure to full, then release
    a_dn.ready = 1'b0;
    a_send(DW_A'(8'h0A));
    a_send(DW_A'(8'h0B));
    a_up.valid = 1'b1;
    a_up.data  = DW_A'(8'h0C);
    idle(3);
    chk("a_full_blocks", a_acc, 1'b0);
    a_dn.ready = 1'b1;
    a_send(DW_A'(8'h0C));
    idle(4);

    // flush with a same-cycle push that must be dropped
    a_dn.ready = 1'b0;
    a_send(DW_A'(8'h21));
    a_send(DW_A'(8'h22));
    a_flush    = 1'b1;
    a_up.valid = 1'b1;
    a_up.data  = DW_A'(8'h0D);
    idle(1);
    a_flush    = 1'b0;
    a_up.valid = 1'b0;
    idle(2);
    a_dn.ready = 1'b1;
    a_send(DW_A'(8'h0E));
    idle(3);

    // flush at count=1 where in_ready reads 1 but the push is still killed
    a_dn.ready = 1'b0;
    a_send(DW_A'(8'h23));
    a_flush    = 1'b1;
    a_up.valid = 1'b1;
    a_up.data  = DW_A'(8'h0D);
    idle(1);
    a_flush    = 1'b0;
    a_up.valid = 1'b0;
    idle(2);

    // hold with consumer ready, then release
    a_send(DW_A'(8'h05));
    a_dn.ready = 1'b1;
    a_hold     = 1'b1;
    idle(3);
    a_hold = 1'b0;
    idle(3);

    // reset mid-operation drops held entries
    a_dn.ready = 1'b0;
    a_send(DW_A'(8'h31));
    a_send(DW_A'(8'h32));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    a_dn.ready = 1'b1;
    idle(3);

    // wrap-around on the DEPTH=4 instance with seeded random consumer stalls
    seed = $urandom(32'h5eed);
    for (int i = 0; i < 11; i++) begin
      t = 0;
      b_up.valid = 1'b1;
      b_up.data  = DW_B'(16'h0040 + i);
      do begin
        b_dn.ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        t++;
      end while (!b_acc && t < 50);
      chk("b_send_accept", b_acc, 1'b1);
    end
    b_up.valid = 1'b0;
    b_dn.ready = 1'b1;
    idle(8);
    chk("b_drained", b_count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline boundary register that replaces the single-entry IF->ID style stage register.
- Small circular buffer of DEPTH entries between a producer stage and a consumer stage, using valid/ready handshakes.
- Upstream ready comes from registered state only, so there is no combinational ready path from consumer to producer.
- Full throughput at DEPTH >= 2.
- Adds a synchronous flush (branch mispredict / trap kill) and a consumer-side hold, which the old stage lacked.

Parameters:
DATA_W, 98, payload width in bits (default = PC 32 + instr 32 + prdt_taken + pc_misalign + bus_err + 31 spare)
DEPTH, 2, number of buffer entries; power of two, 2..8
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  producer has a payload
in_ready  out  1  stage can accept a payload this cycle
in_data  in  DATA_W  producer payload
out_valid  out  1  head entry available to consumer
out_ready  in  1  consumer accepts head this cycle
out_data  out  DATA_W  head entry payload
flush  in  1  discard all held entries and any same-cycle push
hold  in  1  consumer-side stall; masks out_valid, blocks pop
count  out  CNT_W  current occupancy, for perf counters and debug

Behaviour:
- Reset (rst=1 at a clock edge):
  - count=0, rd_ptr=0, wr_ptr=0.
  - Outputs: in_ready=0 while rst is high, out_valid=0, count=0.
  - Storage array is not reset; out_data is undefined while out_valid=0.
  - in_ready rises in the first cycle after rst deasserts.
- Reset mid-operation: all held entries are lost; no pop is reported for them.
- Handshake outputs:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - in_ready = ~rst_q & (count != DEPTH), where rst_q is a registered copy of rst. Registered only; no dependence on out_ready.
  - out_valid = (count != 0) & ~hold.
  - out_data = mem[rd_ptr], combinational read of the head.
- Latency: a payload pushed at edge N is visible on out_data/out_valid in cycle N+1 (one-cycle latency), unless hold or flush intervenes.
- Update each edge:
  - push: mem[wr_ptr]<=in_data, wr_ptr+1.
  - pop: rd_ptr+1.
  - count += push - pop.
- Simultaneous push and pop: count unchanged; legal when not full.
- Full (count=DEPTH): in_ready=0; a pop that cycle frees space for the next cycle only.
- Empty (count=0): out_valid=0; a push this cycle does not bypass to out_data.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH; full/empty are decided by count, not by pointer compare.
- Flush:
  - Next edge: count=0, rd_ptr=wr_ptr=0.
  - A same-cycle in_valid is dropped even though in_ready may read 1; the producer treats flush as a kill of its own output.
  - Priority: rst > flush > push/pop.
- Hold: out_valid=0, no pop; pushes continue until full. When hold drops, the head is presented in that same cycle.
- Payload is opaque; the stage never inspects or modifies field contents.
- No state machine beyond pointer/count; control is fully described by count in 0..DEPTH.

Decomposition:
- Shared package pipe_pkg:
  - PC_WIDTH and INSTR_WIDTH constants.
  - IF->ID payload field offsets (PC_LSB, INSTR_LSB, PRDT_TAKEN_BIT, PC_MISALIGN_BIT, BUS_ERR_BIT).
  - DATA_W default derived from these.
  - Pack/unpack helper functions.
- One sub-module, pipe_fifo_mem: DEPTH x DATA_W register array with one write port and one asynchronous read port. It keeps storage separate from the pointer/count control.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0 throughout; in_ready=1 the cycle after rst drops.
- Streaming: DEPTH=2, out_ready=1, push payloads 0x01..0x10 back-to-back -> one accepted per cycle, each appears one cycle after push in order, count stays <=1.
- Backpressure/full: out_ready=0, push 0xA, 0xB -> count=2, in_ready=0, third payload 0xC held by producer; then out_ready=1 -> 0xA, 0xB, 0xC delivered in order, no loss or duplication.
- Wrap-around: DEPTH=4, 11 pushes with random out_ready (seeded) -> pointers wrap twice, output sequence equals input sequence.
- Flush: count=2, then flush=1 with in_valid=1 in_data=0xD -> next cycle count=0, out_valid=0, 0xD never appears; the next push 0xE appears as the head.
- Hold: count=1 with head 0x5, hold=1 for 3 cycles with out_ready=1 -> out_valid=0, no pop, count unchanged; hold=0 -> out_valid=1 with out_data=0x5 in that same cycle, popped at the next edge.
